// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants for the instruction fetch unit.
//   XLEN / PC_BITWIDTH  : default instruction and program-counter widths
//   FETCH_QUEUE_DEPTH   : default prefetch queue depth (power of two, >= 2)
//   START_ADDR_DEFAULT  : default PC after reset
//   INSTR_BYTES         : byte stride between consecutive instruction words
package instruction_fetch_unit_pkg;
  localparam int unsigned XLEN               = 32;
  localparam int unsigned PC_BITWIDTH        = 32;
  localparam int unsigned FETCH_QUEUE_DEPTH  = 2;
  localparam logic [31:0] START_ADDR_DEFAULT = 32'h0000_0000;
  localparam int unsigned INSTR_BYTES        = 4;
endpackage

// File: rtl/instruction_fetch_unit_queue.sv
// Prefetch queue: synchronous FIFO of {PC, IR} entries.
//   clk, sync_reset : clock, synchronous active-high reset
//   i_push, i_data  : write one entry
//   i_pop           : drop the head entry
//   i_flush         : empty the queue (push/pop ignored that cycle)
//   o_data          : head entry (meaningless when o_empty)
//   o_empty, o_full : occupancy flags
//   o_count         : number of buffered entries
module instruction_fetch_unit_queue
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_QUEUE_DEPTH,
  parameter int unsigned W     = XLEN + PC_BITWIDTH
) (
  input  logic                       clk,
  input  logic                       sync_reset,
  input  logic                       i_push,
  input  logic [W-1:0]               i_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [W-1:0]               o_data,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [CW-1:0] r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (sync_reset || i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + AW'(1);
      if (i_pop)  r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush && !sync_reset) r_mem[r_wr] <= i_data;
  end

  assign o_data  = r_mem[r_rd];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;

  // Credit gating upstream must make these impossible.
  always_ff @(posedge clk) begin
    if (!sync_reset && !i_flush) begin
      assert (!(i_push && o_full && !i_pop)) else $error("fetch queue overflow");
      assert (!(i_pop && o_empty)) else $error("fetch queue underflow");
    end
  end
endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues in-order word reads, buffers returned
// instructions tagged with their PC, and presents them to decode. A redirect
// flushes the queue and marks every still-outstanding response as stale.
//   clk, sync_reset         : clock, synchronous active-high reset
//   fetch_enable            : permit new memory requests
//   jump_enable, jump_addr  : one-cycle redirect from execute
//   mem_req/mem_addr/mem_gnt: request channel (word address, 4-aligned)
//   mem_rvalid/mem_rdata    : in-order response channel
//   decode_ready            : decode consumes the head entry
//   enable_out/IR_out/PC_out: head entry presented to decode
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned XLEN        = instruction_fetch_unit_pkg::XLEN,
  parameter int unsigned PC_BITWIDTH = instruction_fetch_unit_pkg::PC_BITWIDTH,
  parameter int unsigned QUEUE_DEPTH = FETCH_QUEUE_DEPTH,
  parameter logic [PC_BITWIDTH-1:0] START_ADDR = PC_BITWIDTH'(START_ADDR_DEFAULT)
) (
  input  logic                   clk,
  input  logic                   sync_reset,
  input  logic                   fetch_enable,
  input  logic                   jump_enable,
  input  logic [PC_BITWIDTH-1:0] jump_addr,
  output logic                   mem_req,
  output logic [PC_BITWIDTH-1:0] mem_addr,
  input  logic                   mem_gnt,
  input  logic                   mem_rvalid,
  input  logic [XLEN-1:0]        mem_rdata,
  input  logic                   decode_ready,
  output logic                   enable_out,
  output logic [XLEN-1:0]        IR_out,
  output logic [PC_BITWIDTH-1:0] PC_out
);
  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [PC_BITWIDTH-1:0] PC_STEP = PC_BITWIDTH'(INSTR_BYTES);

  logic [PC_BITWIDTH-1:0] r_fetch_pc;
  logic [PC_BITWIDTH-1:0] r_resp_pc;
  logic [CW-1:0]          r_outstanding;
  logic [CW-1:0]          r_discard;
  logic [XLEN-1:0]        r_ir_hold;
  logic [PC_BITWIDTH-1:0] r_pc_hold;

  logic [CW-1:0]          w_count;
  logic [CW:0]            w_inflight;
  logic [CW-1:0]          w_out_next;
  logic                   w_req;
  logic                   w_grant;
  logic                   w_dropping;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_empty;
  logic                   w_full;
  logic [PC_BITWIDTH+XLEN-1:0] w_head;
  logic [PC_BITWIDTH-1:0] w_jump_pc;
  logic                   w_unused;

  // Requests only while issued-but-unreturned plus buffered words leave room,
  // so every response that lands is guaranteed a queue slot.
  assign w_inflight = {1'b0, r_outstanding} + {1'b0, w_count};
  assign w_req      = fetch_enable & ~jump_enable & ~sync_reset &
                      (w_inflight < (CW+1)'(QUEUE_DEPTH));
  assign w_grant    = w_req & mem_gnt;
  assign w_out_next = r_outstanding + CW'(w_grant) - CW'(mem_rvalid);

  assign w_dropping = (r_discard != '0);
  assign w_push     = mem_rvalid & ~w_dropping & ~jump_enable;
  assign w_pop      = ~w_empty & decode_ready & ~jump_enable;
  assign w_jump_pc  = {jump_addr[PC_BITWIDTH-1:2], 2'b00};
  assign w_unused   = ^jump_addr[1:0];

  instruction_fetch_unit_queue #(
    .DEPTH (QUEUE_DEPTH),
    .W     (PC_BITWIDTH + XLEN)
  ) u_fetch_queue (
    .clk        (clk),
    .sync_reset (sync_reset),
    .i_push     (w_push),
    .i_data     ({r_resp_pc, mem_rdata}),
    .i_pop      (w_pop),
    .i_flush    (jump_enable),
    .o_data     (w_head),
    .o_empty    (w_empty),
    .o_full     (w_full),
    .o_count    (w_count)
  );

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      r_fetch_pc    <= START_ADDR;
      r_resp_pc     <= START_ADDR;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_ir_hold     <= '0;
      r_pc_hold     <= '0;
    end else begin
      r_outstanding <= w_out_next;
      // Shadow of the head so outputs keep their last value once drained.
      if (!w_empty) begin
        r_ir_hold <= w_head[XLEN-1:0];
        r_pc_hold <= w_head[PC_BITWIDTH+XLEN-1:XLEN];
      end
      if (jump_enable) begin
        r_fetch_pc <= w_jump_pc;
        r_resp_pc  <= w_jump_pc;
        // Everything still outstanding after this cycle belongs to the old
        // stream; this already includes responses a prior redirect marked.
        r_discard  <= w_out_next;
      end else begin
        if (w_grant) r_fetch_pc <= r_fetch_pc + PC_STEP;
        if (mem_rvalid) begin
          if (w_dropping) r_discard <= r_discard - CW'(1);
          else            r_resp_pc <= r_resp_pc + PC_STEP;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!sync_reset) begin
      assert (w_inflight <= (CW+1)'(QUEUE_DEPTH)) else $error("fetch credit overrun");
      assert (!(w_push && w_full && !w_pop)) else $error("push into full queue");
    end
  end

  assign mem_req    = w_req;
  assign mem_addr   = r_fetch_pc;
  assign enable_out = ~w_empty;
  assign IR_out     = w_empty ? r_ir_hold : w_head[XLEN-1:0];
  assign PC_out     = w_empty ? r_pc_hold : w_head[PC_BITWIDTH+XLEN-1:XLEN];
endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;
  logic        clk = 1'b0;
  logic        sync_reset;
  logic        fetch_enable;
  logic        jump_enable;
  logic [31:0] jump_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        decode_ready;
  logic        enable_out;
  logic [31:0] IR_out;
  logic [31:0] PC_out;

  int checks = 0;
  int failures = 0;
  int gcnt = 0;

  // Memory model controls
  logic        gnt_rand = 1'b0;
  logic        rv_rand  = 1'b0;
  logic        rv_en    = 1'b1;
  logic [31:0] rq[$];

  instruction_fetch_unit dut (
    .clk          (clk),
    .sync_reset   (sync_reset),
    .fetch_enable (fetch_enable),
    .jump_enable  (jump_enable),
    .jump_addr    (jump_addr),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .decode_ready (decode_ready),
    .enable_out   (enable_out),
    .IR_out       (IR_out),
    .PC_out       (PC_out)
  );

  always #5 clk = ~clk;

  // Memory image: each word is derived from its own address.
  function automatic logic [31:0] img(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
  endfunction

  // Track accepted requests; responses leave in request order.
  always @(posedge clk) begin
    if (sync_reset) rq.delete();
    else begin
      if (mem_rvalid) void'(rq.pop_front());
      if (mem_req && mem_gnt) begin
        rq.push_back(mem_addr);
        gcnt++;
      end
    end
  end

  always @(negedge clk) begin
    mem_gnt = gnt_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    if (rq.size() > 0 && (rv_rand ? ($urandom_range(0, 1) == 1) : rv_en)) begin
      mem_rvalid = 1'b1;
      mem_rdata  = img(rq[0]);
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a valid head, check it, and let it pop at the next edge.
  task automatic consume(input logic [31:0] pc, input string tag);
    int n = 0;
    while (!enable_out && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    chk({tag, "_valid"}, 64'(enable_out), 64'd1);
    chk({tag, "_pc"}, 64'(PC_out), 64'(pc));
    chk({tag, "_ir"}, 64'(IR_out), 64'(img(pc)));
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    sync_reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    sync_reset = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_pc;
    sync_reset = 1'b1; fetch_enable = 1'b0; jump_enable = 1'b0;
    jump_addr = 32'h0; decode_ready = 1'b0;
    mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'h0;

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    chk("rst_enable", 64'(enable_out), 64'd0);
    chk("rst_req", 64'(mem_req), 64'd0);
    chk("rst_ir", 64'(IR_out), 64'd0);
    chk("rst_pc", 64'(PC_out), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);

    // Streaming with zero-wait memory
    sync_reset = 1'b0; fetch_enable = 1'b1; decode_ready = 1'b1;
    #1;
    chk("s_req0", 64'(mem_req), 64'd1);
    chk("s_addr0", 64'(mem_addr), 64'd0);
    @(negedge clk); #1;
    chk("s_en_lat1", 64'(enable_out), 64'd0);
    chk("s_addr1", 64'(mem_addr), 64'd4);
    @(negedge clk); #1;
    chk("s_en_lat2", 64'(enable_out), 64'd1);
    consume(32'h0, "s0");
    consume(32'h4, "s4");
    chk("s_hold_en", 64'(enable_out), 64'd0);
    chk("s_hold_pc", 64'(PC_out), 64'd4);
    consume(32'h8, "s8");
    consume(32'hC, "sC");

    // Back-pressure: queue fills, requests stop after two grants
    decode_ready = 1'b0;
    do_reset();
    gcnt = 0;
    repeat (8) @(negedge clk);
    #1;
    chk("bp_grants", 64'(gcnt), 64'd2);
    chk("bp_req", 64'(mem_req), 64'd0);
    chk("bp_head", 64'(PC_out), 64'd0);
    chk("bp_addr", 64'(mem_addr), 64'd8);
    fetch_enable = 1'b0; #1;
    chk("fe_low_req", 64'(mem_req), 64'd0);
    fetch_enable = 1'b1;
    decode_ready = 1'b1;
    consume(32'h0, "bp0");
    consume(32'h4, "bp4");
    consume(32'h8, "bp8");

    // Redirect with two requests outstanding
    rv_en = 1'b0;
    do_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("j_pre_req", 64'(mem_req), 64'd0);
    jump_enable = 1'b1; jump_addr = 32'h100; #1;
    chk("j_cycle_req", 64'(mem_req), 64'd0);
    @(negedge clk);
    jump_enable = 1'b0; rv_en = 1'b1; #1;
    chk("j_flush_en", 64'(enable_out), 64'd0);
    chk("j_addr", 64'(mem_addr), 64'h100);
    consume(32'h100, "j100");
    consume(32'h104, "j104");

    // Unaligned redirect target
    jump_enable = 1'b1; jump_addr = 32'h103;
    @(negedge clk);
    jump_enable = 1'b0; #1;
    chk("ua_addr", 64'(mem_addr), 64'h100);
    consume(32'h100, "ua100");

    // Back-to-back redirects while responses are outstanding
    rv_en = 1'b0;
    do_reset();
    repeat (3) @(negedge clk);
    #1;
    jump_enable = 1'b1; jump_addr = 32'h200;
    @(negedge clk);
    jump_addr = 32'h300;
    @(negedge clk);
    jump_enable = 1'b0; rv_en = 1'b1;
    #1;
    consume(32'h300, "bb300");
    consume(32'h304, "bb304");
    consume(32'h308, "bb308");

    // Random grant/response/decode stalls
    gnt_rand = 1'b1; rv_rand = 1'b1;
    do_reset();
    exp_pc = 32'h0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      decode_ready = ($urandom_range(0, 1) == 1);
      #1;
      if (enable_out && decode_ready) begin
        chk("rnd_pc", 64'(PC_out), 64'(exp_pc));
        chk("rnd_ir", 64'(IR_out), 64'(img(PC_out)));
        exp_pc = exp_pc + 32'd4;
      end
    end
    chk("rnd_progress", 64'(exp_pc >= 32'h40), 64'd1);

    // Reset with a full queue
    gnt_rand = 1'b0; rv_rand = 1'b0; rv_en = 1'b1; decode_ready = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("fr_full_en", 64'(enable_out), 64'd1);
    sync_reset = 1'b1;
    @(negedge clk); #1;
    chk("fr_req", 64'(mem_req), 64'd0);
    sync_reset = 1'b0; #1;
    chk("fr_en", 64'(enable_out), 64'd0);
    chk("fr_addr", 64'(mem_addr), 64'd0);
    chk("fr_pc", 64'(PC_out), 64'd0);
    chk("fr_ir", 64'(IR_out), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
